hilo_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit owning the HI/LO register pair.
//  - Sits beside the EX stage and sources hi_signal_ID/lo_signal_ID into the ID/EX pipeline register.
//  - Accepts MULT/MULTU/DIV/DIVU operands from EX and takes MTHI/MTLO writes from the MEM/WB register.
//  - Raises a stall request toward hazard control while an operation is in flight.

---
 rtl/hilo_muldiv_unit.sv | 131 +++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative multiply/divide unit that owns the HI/LO register pair.
//   clk, reset          : clock, synchronous active-high reset
//   op_valid, op_code   : issue from EX (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   rs_val, rt_val      : multiplicand/dividend, multiplier/divisor
//   wb_hi_we, wb_lo_we  : MTHI/MTLO writes from WB carrying wb_data
//   id_reads_hilo       : ID holds an instruction touching HI/LO
//   hi_out, lo_out      : bypassed HI/LO toward ID
//   busy, done          : operation in flight / one-cycle completion pulse
//   stall_req           : freeze IF/ID/EX
module hilo_muldiv_unit #(
   parameter int XLEN            = 32,
   parameter int STEPS_PER_CYCLE = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            op_valid,
   input  logic [1:0]      op_code,
   input  logic [XLEN-1:0] rs_val,
   input  logic [XLEN-1:0] rt_val,
   input  logic            wb_hi_we,
   input  logic            wb_lo_we,
   input  logic [XLEN-1:0] wb_data,
   input  logic            id_reads_hilo,
   output logic [XLEN-1:0] hi_out,
   output logic [XLEN-1:0] lo_out,
   output logic            busy,
   output logic            done,
   output logic            stall_req
);
   localparam int N  = XLEN / STEPS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   m_q, m_d, hi_q, hi_d, lo_q, lo_d;
   logic [2*XLEN-1:0] p_q, p_d, p_step, prod;
   logic              div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, done_q, done_d;
   logic              sgn;
   logic [XLEN-1:0]   abs_rs, abs_rt, quo, rem, res_hi, res_lo;
   // One step on {upper,lower}. Multiply: shift-add with the multiplier in
   // the low half. Divide: restoring step with remainder high, quotient low.
   function automatic logic [2*XLEN-1:0] step(input logic [2*XLEN-1:0] p,
                                              input logic [XLEN-1:0] m,
                                              input logic dv);
      logic [XLEN:0] s, d;
      s = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, m} : '0);
      d = p[2*XLEN-1:XLEN-1] - {1'b0, m};
      step = !dv ? {s, p[XLEN-1:1]}
           : d[XLEN] ? {p[2*XLEN-2:0], 1'b0}
           : {d[XLEN-1:0], p[XLEN-2:0], 1'b1};
   endfunction
   assign sgn    = ~op_code[0];
   assign abs_rs = (sgn & rs_val[XLEN-1]) ? -rs_val : rs_val;
   assign abs_rt = (sgn & rt_val[XLEN-1]) ? -rt_val : rt_val;
   always_comb begin
      p_step = p_q;
      for (int i = 0; i < STEPS_PER_CYCLE; i++) p_step = step(p_step, m_q, div_q);
   end
   // Sign fix-up. A zero divisor leaves the remainder equal to |rs|, so the
   // remainder sign correction already restores rs; only LO needs overriding.
   assign prod   = neg_q ? -p_q : p_q;
   assign quo    = p_q[XLEN-1:0];
   assign rem    = p_q[2*XLEN-1:XLEN];
   assign res_lo = !div_q ? prod[XLEN-1:0] : (m_q == '0) ? '1 : neg_q ? -quo : quo;
   assign res_hi = !div_q ? prod[2*XLEN-1:XLEN] : rneg_q ? -rem : rem;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      m_d     = m_q;
      p_d     = p_q;
      div_d   = div_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      done_d  = 1'b0;
      hi_d    = wb_hi_we ? wb_data : hi_q;
      lo_d    = wb_lo_we ? wb_data : lo_q;
      case (state_q)
         IDLE: if (op_valid) begin
            div_d   = op_code[1];
            m_d     = op_code[1] ? abs_rt : abs_rs;
            p_d     = {{XLEN{1'b0}}, op_code[1] ? abs_rs : abs_rt};
            neg_d   = sgn & (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
            rneg_d  = sgn & rs_val[XLEN-1];
            cnt_d   = '0;
            state_d = CALC;
         end
         CALC: begin
            p_d     = p_step;
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(N - 1)) ? FIX : CALC;
         end
         FIX: begin
            hi_d    = res_hi;
            lo_d    = res_lo;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         m_q     <= '0;
         p_q     <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         m_q     <= m_d;
         p_q     <= p_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end
   assign busy      = state_q != IDLE;
   assign done      = done_q;
   assign stall_req = busy & (op_valid | id_reads_hilo);
   assign hi_out    = wb_hi_we ? wb_data : hi_q;
   assign lo_out    = wb_lo_we ? wb_data : lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: directed and random checks of hilo_muldiv_unit against an arithmetic model.
module tb_hilo_muldiv_unit;
   logic        clk = 1'b0, reset = 1'b1, op_valid = 1'b0, wb_hi_we = 1'b0, wb_lo_we = 1'b0, id_reads_hilo = 1'b0;
   logic [1:0]  op_code = 2'b00;
   logic [31:0] rs_val = '0, rt_val = '0, wb_data = '0, hi_out, lo_out;
   logic        busy, done, stall_req;
   int          passed = 0, total = 0;
   hilo_muldiv_unit dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
      .rs_val(rs_val), .rt_val(rt_val), .wb_hi_we(wb_hi_we), .wb_lo_we(wb_lo_we),
      .wb_data(wb_data), .id_reads_hilo(id_reads_hilo), .hi_out(hi_out), .lo_out(lo_out),
      .busy(busy), .done(done), .stall_req(stall_req)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask
   // Reference: 64-bit integer arithmetic, truncating division, MIPS special cases.
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      sa = op[0] ? longint'({32'b0, a}) : longint'($signed(a));
      sb = op[0] ? longint'({32'b0, b}) : longint'($signed(b));
      if (!op[1]) return 64'(sa * sb);
      if (b == 0) return {a, 32'hFFFF_FFFF};
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction
   task automatic wait_done(output int lat, output int bc);
      lat = 1;
      bc  = 0;
      while (!done && lat < 100) begin
         if (busy) bc++;
         @(posedge clk); #1;
         lat++;
      end
   endtask
   task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [63:0] exp;
      int lat, bc;
      exp = model(op, a, b);
      @(negedge clk);
      op_valid = 1'b1; op_code = op; rs_val = a; rt_val = b;
      #1 chk({tag, "_stall_idle"}, 64'(stall_req), 64'd0);
      @(posedge clk); #1;
      op_valid = 1'b0;
      wait_done(lat, bc);
      chk({tag, "_latency"}, 64'(lat), 64'd34);
      chk({tag, "_busycycles"}, 64'(bc), 64'd33);
      chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      chk({tag, "_hilo"}, {hi_out, lo_out}, exp);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, 64'(done), 64'd0);
   endtask
   initial begin
      int lat, bc;
      logic [1:0] rop;
      logic [31:0] ra, rb;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hilo", {hi_out, lo_out}, 64'd0);
      do_op(2'b00, 32'd7, -32'sd3, "t1_mult");
      chk("t1_const", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFEB);
      do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t2_multu");
      chk("t2_const", {hi_out, lo_out}, 64'hFFFFFFFE_00000001);
      do_op(2'b10, -32'sd7, 32'd2, "t3_div");
      chk("t3_div_const", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFFD);
      do_op(2'b11, 32'd100, 32'd7, "t3_divu");
      chk("t3_divu_const", {hi_out, lo_out}, {32'd2, 32'd14});
      do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "t3_ovf");
      chk("t3_ovf_const", {hi_out, lo_out}, 64'h00000000_80000000);
      do_op(2'b11, 32'h1234, 32'd0, "t4_dz");
      chk("t4_const", {hi_out, lo_out}, 64'h00001234_FFFFFFFF);
      do_op(2'b10, -32'sd50, 32'd0, "t4_dz_signed");
      for (int i = 0; i < 12; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i % 3 == 2) ? 32'($urandom_range(0, 9)) : $urandom;
         if (i % 4 == 1) ra = {{28{ra[31]}}, ra[3:0]};
         do_op(rop, ra, rb, $sformatf("rnd%0d", i));
      end
      // T5: second issue and HI/LO reader while busy
      @(negedge clk);
      op_valid = 1'b1; op_code = 2'b01; rs_val = 32'd6; rt_val = 32'd7;
      @(posedge clk); #1;
      op_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 op_valid = 1'b1; op_code = 2'b11; rs_val = 32'd9; rt_val = 32'd3;
      #1 chk("t5_stall_op", 64'(stall_req), 64'd1);
      @(posedge clk); #1;
      op_valid = 1'b0; id_reads_hilo = 1'b1;
      #1 chk("t5_stall_id", 64'(stall_req), 64'd1);
      id_reads_hilo = 1'b0;
      #1 chk("t5_stall_none", 64'(stall_req), 64'd0);
      wait_done(lat, bc);
      chk("t5_done_seen", 64'(done), 64'd1);
      chk("t5_hilo", {hi_out, lo_out}, 64'd42);
      wb_lo_we = 1'b1; wb_data = 32'hA5;
      #1 chk("t5_bypass", 64'(lo_out), 64'hA5);
      @(posedge clk); #1;
      wb_lo_we = 1'b0; wb_data = 32'h0;
      #1 chk("t5_lo_written", {hi_out, lo_out}, 64'hA5);
      // T6: reset during CALC cycle 10
      @(negedge clk);
      op_valid = 1'b1; op_code = 2'b00; rs_val = 32'd7; rt_val = -32'sd3;
      @(posedge clk); #1;
      op_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 chk("t6_busy_calc", 64'(busy), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("t6_busy", 64'(busy), 64'd0);
      chk("t6_done", 64'(done), 64'd0);
      chk("t6_hilo", {hi_out, lo_out}, 64'd0);
      do_op(2'b01, 32'd3, 32'd5, "t6_multu");
      chk("t6_const", {hi_out, lo_out}, 64'd15);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
